// File: rtl/squid_pkg.sv
// Shared SQUID types and constants.
// Provides the weight / virtual-parity element types, the slot-state
// encoding used by the weight unpacker, the default-geometry slot struct
// and a helper that normalises an incoming lane count.
package squid_pkg;

    localparam int W_BITS   = 6;
    localparam int VP_BITS  = 4;
    localparam int SLOT_WPL = 8;

    typedef logic [W_BITS-1:0]  weight_t;
    typedef logic [VP_BITS-1:0] vp_t;

    // Buffer occupancy, encoded as {cur_v, nxt_v}; 2'b01 is illegal.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_TWO   = 2'b11
    } slot_state_e;

    // One buffered memory line at the default geometry.
    typedef struct packed {
        weight_t [SLOT_WPL-1:0]          weight;
        vp_t     [SLOT_WPL-1:0]          vp;
        logic [$clog2(SLOT_WPL+1)-1:0]   nvalid;
        logic                            last;
    } squid_slot_t;

    // A lane count of 0 or above the line width means "the whole line".
    function automatic int unsigned norm_nvalid(input int unsigned n, input int unsigned wpl);
        return ((n == 0) || (n > wpl)) ? wpl : n;
    endfunction

endpackage

// File: rtl/squid_lane_sel.sv
// Combinational lane selector for the SQUID weight unpacker.
// Picks lane idx_i out of the current line and forces the result to zero
// when the slot is not valid, so downstream never sees stale data.
// Ports:
//   valid_i   current slot holds a line
//   idx_i     lane to present
//   weight_i  all lane weights of the current line
//   vp_i      all lane parity nibbles of the current line
//   weight_o  selected weight (0 when invalid)
//   vp_o      selected parity (0 when invalid)
module squid_lane_sel
    import squid_pkg::*;
#(
    parameter int WPL   = 8,
    parameter int IDX_W = $clog2(WPL)
)
(
    input  logic                 valid_i,
    input  logic [IDX_W-1:0]     idx_i,
    input  weight_t [WPL-1:0]    weight_i,
    input  vp_t     [WPL-1:0]    vp_i,
    output logic [W_BITS-1:0]    weight_o,
    output logic [VP_BITS-1:0]   vp_o
);

    always_comb begin
        weight_o = '0;
        vp_o     = '0;
        if (valid_i) begin
            weight_o = weight_i[idx_i];
            vp_o     = vp_i[idx_i];
        end
    end

endmodule

// File: rtl/squid_weight_unpacker.sv
// SQUID weight unpacker: turns packed memory lines (WPL weights plus WPL
// virtual-parity nibbles) into a one-pair-per-cycle valid/ready stream for
// the first-level decoder. Two line slots (CUR being serialised, NXT
// prefetched) give 1 weight/clk with no bubble at line boundaries.
// Ports:
//   clk, rst                      clock, async active-high reset
//   line_valid_i / line_ready_o   input line handshake (ready = NXT empty)
//   line_weight_i, line_vp_i      lane k at [k*6 +: 6] / [k*4 +: 4]
//   line_nvalid_i                 lanes used (0 or >WPL means WPL)
//   line_last_i                   final line of the tensor
//   out_valid_o / out_ready_i     output handshake
//   weight_o, vp_o, idx_o         current lane (all zero when not valid)
//   last_o                        last lane of a last line
// Optional: define SQUID_UNPACK_PERF_EN to add stall_cnt_o (valid but
// not-ready cycles) and line_cnt_o (lines accepted), both 32-bit wrapping.
module squid_weight_unpacker
    import squid_pkg::*;
#(
    parameter  int WPL   = 8,
    localparam int IDX_W = $clog2(WPL),
    localparam int CNT_W = $clog2(WPL+1)
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   line_valid_i,
    output logic                   line_ready_o,
    input  logic [WPL*W_BITS-1:0]  line_weight_i,
    input  logic [WPL*VP_BITS-1:0] line_vp_i,
    input  logic [CNT_W-1:0]       line_nvalid_i,
    input  logic                   line_last_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [W_BITS-1:0]      weight_o,
    output logic [VP_BITS-1:0]     vp_o,
    output logic [IDX_W-1:0]       idx_o,
    output logic                   last_o
`ifdef SQUID_UNPACK_PERF_EN
    ,
    output logic [31:0]            stall_cnt_o,
    output logic [31:0]            line_cnt_o
`endif
);

    typedef struct packed {
        weight_t [WPL-1:0]  weight;
        vp_t     [WPL-1:0]  vp;
        logic [CNT_W-1:0]   nvalid;
        logic               last;
    } slot_t;

    slot_state_e       state_q;
    slot_t             cur_q;
    slot_t             nxt_q;
    slot_t             in_slot;
    logic [IDX_W-1:0]  idx_q;
    logic              cur_v;
    logic              nxt_v;
    logic              accept;
    logic              fire;
    logic              at_end;
    logic              retire;

    assign cur_v = state_q[1];
    assign nxt_v = state_q[0];

    // Incoming line with its lane count already normalised.
    always_comb begin
        in_slot        = '0;
        in_slot.weight = line_weight_i;
        in_slot.vp     = line_vp_i;
        in_slot.nvalid = CNT_W'(norm_nvalid(32'(line_nvalid_i), WPL));
        in_slot.last   = line_last_i;
    end

    // Ready depends only on registered occupancy, never on out_ready_i.
    assign line_ready_o = !nxt_v;
    assign accept       = line_valid_i && line_ready_o;
    assign fire         = cur_v && out_ready_i;
    assign at_end       = (CNT_W'(idx_q) == (cur_q.nvalid - CNT_W'(1)));
    assign retire       = fire && at_end;

    // Slot FSM: a retiring CUR is refilled from NXT first, otherwise from a
    // line accepted on the same edge, so back-to-back lines never bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            cur_q   <= '0;
            nxt_q   <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        cur_q   <= in_slot;
                        idx_q   <= '0;
                        state_q <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (retire) begin
                        idx_q <= '0;
                        if (accept) begin
                            cur_q <= in_slot;
                        end else begin
                            state_q <= ST_EMPTY;
                        end
                    end else begin
                        if (fire) begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                        if (accept) begin
                            nxt_q   <= in_slot;
                            state_q <= ST_TWO;
                        end
                    end
                end
                ST_TWO: begin
                    if (retire) begin
                        idx_q   <= '0;
                        cur_q   <= nxt_q;
                        state_q <= ST_ONE;
                    end else if (fire) begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    squid_lane_sel #(
        .WPL   (WPL),
        .IDX_W (IDX_W)
    ) u_lane_sel (
        .valid_i  (cur_v),
        .idx_i    (idx_q),
        .weight_i (cur_q.weight),
        .vp_i     (cur_q.vp),
        .weight_o (weight_o),
        .vp_o     (vp_o)
    );

    assign out_valid_o = cur_v;
    assign idx_o       = cur_v ? idx_q : '0;
    assign last_o      = cur_v && cur_q.last && at_end;

`ifdef SQUID_UNPACK_PERF_EN
    // Free-running wrapping counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_o <= '0;
            line_cnt_o  <= '0;
        end else begin
            if (cur_v && !out_ready_i) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (accept) begin
                line_cnt_o <= line_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_squid_weight_unpacker.sv
// Self-checking bench for squid_weight_unpacker.
// A lane-level queue model tracks what must come out and how many lines
// are buffered; a negedge compare process checks every cycle.
module tb_squid_weight_unpacker;

    localparam int WPL   = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 line_valid_i = 1'b0;
    logic                 line_ready_o;
    logic [WPL*6-1:0]     line_weight_i = '0;
    logic [WPL*4-1:0]     line_vp_i = '0;
    logic [CNT_W-1:0]     line_nvalid_i = '0;
    logic                 line_last_i = 1'b0;
    logic                 out_valid_o;
    logic                 out_ready_i = 1'b1;
    logic [5:0]           weight_o;
    logic [3:0]           vp_o;
    logic [IDX_W-1:0]     idx_o;
    logic                 last_o;
`ifdef SQUID_UNPACK_PERF_EN
    logic [31:0]          stall_cnt_o;
    logic [31:0]          line_cnt_o;
`endif

    squid_weight_unpacker #(.WPL(WPL)) dut (
        .clk           (clk),
        .rst           (rst),
        .line_valid_i  (line_valid_i),
        .line_ready_o  (line_ready_o),
        .line_weight_i (line_weight_i),
        .line_vp_i     (line_vp_i),
        .line_nvalid_i (line_nvalid_i),
        .line_last_i   (line_last_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .weight_o      (weight_o),
        .vp_o          (vp_o),
        .idx_o         (idx_o),
        .last_o        (last_o)
`ifdef SQUID_UNPACK_PERF_EN
        ,
        .stall_cnt_o   (stall_cnt_o),
        .line_cnt_o    (line_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] w;
        logic [3:0] vp;
        logic [2:0] idx;
        logic       last;
        logic       eol;
    } lane_t;

    lane_t expQ[$];
    int    buffered   = 0;
    int    fireCount  = 0;
    int    lastCount  = 0;
    int    stallModel = 0;
    int    lineModel  = 0;
    int    assertCount = 0;
    int    failCount   = 0;
    int    readyMode   = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic boundExpired(input string name);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Model + compare: check first, then advance the model on this cycle's handshakes.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rstValid", out_valid_o, 0);
            checkOutput("rstReady", line_ready_o, 1);
            checkOutput("rstData", {weight_o, vp_o, idx_o, last_o}, 0);
            expQ.delete();
            buffered   = 0;
            stallModel = 0;
            lineModel  = 0;
        end else begin
            lane_t e;
            bit    mFire;
            bit    mAccept;
            int    nv;
            checkOutput("outValid", out_valid_o, buffered > 0);
            checkOutput("lineReady", line_ready_o, buffered < 2);
`ifdef SQUID_UNPACK_PERF_EN
            checkOutput("stallCnt", stall_cnt_o, 32'(stallModel));
            checkOutput("lineCnt", line_cnt_o, 32'(lineModel));
`endif
            if (buffered > 0 && expQ.size() > 0) begin
                e = expQ[0];
                checkOutput("weight", weight_o, e.w);
                checkOutput("vp", vp_o, e.vp);
                checkOutput("idx", idx_o, e.idx);
                checkOutput("last", last_o, e.last);
            end else if (buffered == 0) begin
                checkOutput("idleZero", {weight_o, vp_o, idx_o, last_o}, 0);
            end
            mFire   = (buffered > 0) && out_ready_i;
            mAccept = line_valid_i && (buffered < 2);
            if (buffered > 0 && !out_ready_i) stallModel++;
            if (mFire) begin
                fireCount++;
                if (last_o) lastCount++;
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    if (e.eol) buffered--;
                end
            end
            if (mAccept) begin
                lineModel++;
                nv = (line_nvalid_i == 0 || line_nvalid_i > WPL) ? WPL : int'(line_nvalid_i);
                for (int k = 0; k < nv; k++) begin
                    e.w    = line_weight_i[k*6 +: 6];
                    e.vp   = line_vp_i[k*4 +: 4];
                    e.idx  = 3'(k);
                    e.last = line_last_i && (k == nv - 1);
                    e.eol  = (k == nv - 1);
                    expQ.push_back(e);
                end
                buffered++;
            end
        end
    end

    // Downstream ready pattern.
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = !out_ready_i;
            default: out_ready_i = ($urandom % 4) != 0;
        endcase
    end

    // Present one line and hold it until it is taken.
    task automatic applyStimulus(input logic [WPL*6-1:0] w, input logic [WPL*4-1:0] v,
                                 input logic [CNT_W-1:0] n, input logic last);
        bit acc = 0;
        line_weight_i = w;
        line_vp_i     = v;
        line_nvalid_i = n;
        line_last_i   = last;
        line_valid_i  = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            acc = line_ready_o;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) boundExpired("acceptTimeout");
        line_valid_i = 1'b0;
    endtask

    task automatic waitDrain();
        for (int t = 0; t < 20000 && buffered != 0; t++) begin
            @(posedge clk);
            #1;
        end
        if (buffered != 0) boundExpired("drainTimeout");
    endtask

    task automatic randomLine(output logic [WPL*6-1:0] w, output logic [WPL*4-1:0] v);
        for (int k = 0; k < WPL; k++) begin
            w[k*6 +: 6] = 6'($urandom);
            v[k*4 +: 4] = 4'($urandom);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [WPL*6-1:0] w;
        logic [WPL*4-1:0] v;
        int fc0;
        int lc0;
        int seen;
        int lastSent;
        int lanesSent;
        int n;

        // Reset and idle state.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("postRstValid", out_valid_o, 0);
        checkOutput("postRstReady", line_ready_o, 1);
        @(posedge clk);
        #1;

        // 1: single full line, lane k = (k+1, k).
        for (int k = 0; k < WPL; k++) begin
            w[k*6 +: 6] = 6'(k + 1);
            v[k*4 +: 4] = 4'(k);
        end
        applyStimulus(w, v, 4'd8, 1'b0);
        for (int k = 0; k < WPL; k++) begin
            @(negedge clk);
            checkOutput("t1Valid", out_valid_o, 1);
            checkOutput("t1Weight", weight_o, 64'(k + 1));
            checkOutput("t1Vp", vp_o, 64'(k));
            checkOutput("t1Idx", idx_o, 64'(k));
        end
        waitDrain();

        // 2: three back-to-back lines.
        fc0 = fireCount;
        for (int i = 0; i < 3; i++) begin
            randomLine(w, v);
            applyStimulus(w, v, 4'd8, 1'b0);
        end
        waitDrain();
        checkOutput("t2Lanes", fireCount - fc0, 24);

        // 3: partial last line, then nvalid=0 meaning whole line.
        fc0 = fireCount;
        lc0 = lastCount;
        randomLine(w, v);
        applyStimulus(w, v, 4'd3, 1'b1);
        waitDrain();
        checkOutput("t3Lanes", fireCount - fc0, 3);
        checkOutput("t3Lasts", lastCount - lc0, 1);
        fc0 = fireCount;
        randomLine(w, v);
        applyStimulus(w, v, 4'd0, 1'b0);
        waitDrain();
        checkOutput("t3ZeroLanes", fireCount - fc0, 8);

        // 4: alternating ready, lane 4 carries 6'h2A.
        readyMode = 1;
        fc0  = fireCount;
        seen = 0;
        randomLine(w, v);
        w[4*6 +: 6] = 6'h2A;
        applyStimulus(w, v, 4'd8, 1'b0);
        for (int t = 0; t < 40 && buffered != 0; t++) begin
            @(negedge clk);
            if (out_valid_o && idx_o == 3'd4) begin
                seen++;
                checkOutput("t4Hold", weight_o, 6'h2A);
            end
        end
        waitDrain();
        checkOutput("t4Seen", seen > 0, 1);
        checkOutput("t4Lanes", fireCount - fc0, 8);
        readyMode = 0;
        @(posedge clk);
        #1;

        // 5: reset mid-line with NXT full.
        randomLine(w, v);
        applyStimulus(w, v, 4'd8, 1'b0);
        randomLine(w, v);
        applyStimulus(w, v, 4'd8, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t5Full", line_ready_o, 0);
        rst = 1'b1;
        #1;
        checkOutput("t5RstValid", out_valid_o, 0);
        checkOutput("t5RstReady", line_ready_o, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        randomLine(w, v);
        w[5:0] = 6'h15;
        applyStimulus(w, v, 4'd4, 1'b0);
        @(negedge clk);
        checkOutput("t5FreshIdx", idx_o, 0);
        checkOutput("t5FreshWeight", weight_o, 6'h15);
        waitDrain();

        // 6: random lines, random gaps, random ready.
        readyMode = 2;
        fc0 = fireCount;
        lc0 = lastCount;
        lastSent  = 0;
        lanesSent = 0;
        for (int i = 0; i < 2000; i++) begin
            randomLine(w, v);
            n = int'($urandom % 16);
            lanesSent += (n == 0 || n > WPL) ? WPL : n;
            if (($urandom % 4) == 0) begin
                lastSent++;
                applyStimulus(w, v, 4'(n), 1'b1);
            end else begin
                applyStimulus(w, v, 4'(n), 1'b0);
            end
            if (($urandom % 4) == 0) begin
                repeat ($urandom % 3) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        waitDrain();
        checkOutput("t6Lanes", fireCount - fc0, 64'(lanesSent));
        checkOutput("t6Lasts", lastCount - lc0, 64'(lastSent));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
